// File: rtl/fpga_link_tx.sv
`timescale 1ns/1ps
// Word transmitter for an inter-board link: one bit per 4-phase req/ack handshake,
// per-edge timeout, and whole-word retry from a held copy of the captured word.
module fpga_link_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int MAX_RETRY      = 3,
    parameter int MSB_FIRST      = 1,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sent,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  acknowledge,
    output logic                  sendToOther,
    output logic                  tx_data,
    output logic                  busy,
    output logic                  finish,
    output logic                  error,
    output logic [RW-1:0]         retry_cnt,
    output logic [2:0]            state_dbg
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_REQ  = 3'd2,
        S_ACKH = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5,
        S_FAIL = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic                  ack_meta_q, ack_s_q;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic                  tx_q, tx_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  finish_q, finish_d;
    logic                  error_q, error_d;
    logic                  ack_evt;
    logic                  timer_end;

    function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    assign shifted   = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
    assign timer_end = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    // REQ waits for ack high; ARM and ACKH wait for ack low.
    assign ack_evt   = (state_q == S_REQ) ? ack_s_q : !ack_s_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            word_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            tx_q       <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_meta_q <= acknowledge;
            ack_s_q    <= ack_meta_q;
            word_q     <= word_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            tx_q       <= tx_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
            error_q    <= error_d;
        end
    end

    // Timer clears on any transition (including a retry back into ARM) and
    // counts only while a wait state is held.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        retry_d   = retry_q;
        tx_d      = tx_q;
        timer_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (sent) begin
                    word_d    = data_in;
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    retry_d   = '0;
                    state_d   = S_ARM;
                end
            end
            S_ARM, S_REQ, S_ACKH: begin
                if (ack_evt) begin
                    if (state_q == S_ARM) begin
                        tx_d    = lead_bit(shift_q);
                        state_d = S_REQ;
                    end else if (state_q == S_REQ) begin
                        state_d = S_ACKH;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (timer_end) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d   = retry_q + RW'(1);
                        shift_d   = word_q;
                        bit_cnt_d = '0;
                        state_d   = S_ARM;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_NEXT: begin
                if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    tx_d      = lead_bit(shifted);
                    state_d   = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake: req rises one cycle after entering REQ, so tx_data (loaded on
    // REQ entry) is stable a full cycle before req; req falls on leaving REQ and
    // the remote then drops acknowledge to close the 4-phase cycle.
    always_comb begin
        req_d    = (state_q == S_REQ) && (state_d == S_REQ);
        busy_d   = (state_d != S_IDLE);
        finish_d = (state_d == S_DONE);
        error_d  = (state_d == S_FAIL);
    end

    assign sendToOther = req_q;
    assign tx_data     = tx_q;
    assign busy        = busy_q;
    assign finish      = finish_q;
    assign error       = error_q;
    assign retry_cnt   = retry_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fpga_link_tx.sv
`timescale 1ns/1ps
// Bench for fpga_link_tx: main instance (MSB first, short timeout) with a scripted
// remote, plus an LSB-first instance with a plain delayed-echo remote.
module tb_fpga_link_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       sent;
    logic [7:0] data_in;
    logic       acknowledge;
    logic       sendToOther, tx_data, busy, finish, error;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    logic       lsb_sent;
    logic [7:0] lsb_data;
    logic       lsb_ack;
    logic       lsb_req, lsb_tx, lsb_busy, lsb_fin, lsb_err;
    logic [1:0] lsb_retry;
    logic [2:0] lsb_state;

    logic [0:0] exp_bit_q[$];
    logic [0:0] exp_lsb_q[$];
    logic [7:0] exp_evt_q[$];

    int checks = 0;
    int errors = 0;
    int pulses = 0, fin_cnt = 0, err_cnt = 0;
    int lsb_fin_cnt = 0, lsb_err_cnt = 0;
    int req_idx = 0, drop_idx = -1;
    bit remote_hold = 1'b0, remote_silent = 1'b0;

    always #5 clk = ~clk;

    fpga_link_tx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .MAX_RETRY(2), .MSB_FIRST(1)) u_dut (
        .clk(clk), .reset(reset), .sent(sent), .data_in(data_in), .acknowledge(acknowledge),
        .sendToOther(sendToOther), .tx_data(tx_data), .busy(busy), .finish(finish),
        .error(error), .retry_cnt(retry_cnt), .state_dbg(state_dbg)
    );

    fpga_link_tx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .MAX_RETRY(2), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .sent(lsb_sent), .data_in(lsb_data), .acknowledge(lsb_ack),
        .sendToOther(lsb_req), .tx_data(lsb_tx), .busy(lsb_busy), .finish(lsb_fin),
        .error(lsb_err), .retry_cnt(lsb_retry), .state_dbg(lsb_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Remote for the main instance: acks 3 cycles after each req edge, with hold/silent/drop modes.
    initial begin
        int  rcnt;
        bit  counted;
        rcnt = 0;
        counted = 1'b0;
        acknowledge = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                acknowledge = 1'b0;
                rcnt = 0;
                counted = 1'b0;
            end else if (remote_hold) begin
                acknowledge = 1'b1;
                rcnt = 0;
            end else if (sendToOther && !acknowledge) begin
                if (!counted) begin
                    req_idx++;
                    counted = 1'b1;
                end
                if (remote_silent || req_idx == drop_idx) begin
                    rcnt = 0;
                end else begin
                    rcnt++;
                    if (rcnt >= 3) begin
                        acknowledge = 1'b1;
                        rcnt = 0;
                    end
                end
            end else if (!sendToOther && acknowledge) begin
                rcnt++;
                if (rcnt >= 3) begin
                    acknowledge = 1'b0;
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
            if (!sendToOther) counted = 1'b0;
        end
    end

    // Monitor for the main instance: bit per req rising edge, events on finish/error.
    initial begin
        bit prev_req, prev_tx, cur_bit;
        prev_req = 1'b0;
        prev_tx  = 1'b0;
        cur_bit  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req = 1'b0;
                prev_tx  = 1'b0;
                continue;
            end
            if (sendToOther && !prev_req) begin
                pulses++;
                check("tx_setup", tx_data, prev_tx);
                if (exp_bit_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_bit unexpected req pulse tx=%0b expected none", tx_data);
                end else begin
                    check("tx_bit", tx_data, exp_bit_q.pop_front());
                end
                cur_bit = tx_data;
            end else if (sendToOther) begin
                check("tx_hold", tx_data, cur_bit);
            end
            if (finish || error) begin
                if (finish) fin_cnt++;
                if (error)  err_cnt++;
                check("busy_at_pulse", busy, 1);
                if (exp_evt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL event unexpected finish=%0b error=%0b expected none", finish, error);
                end else begin
                    check("event", {2'b00, error, finish, 2'b00, retry_cnt}, exp_evt_q.pop_front());
                end
            end
            prev_req = sendToOther;
            prev_tx  = tx_data;
        end
    end

    // LSB-first instance: remote echoes req after 3 cycles; monitor checks its bits.
    initial begin
        logic [2:0] dly;
        bit         prev;
        dly = '0;
        prev = 1'b0;
        lsb_ack = 1'b0;
        forever begin
            @(negedge clk);
            dly = {dly[1:0], lsb_req};
            lsb_ack = dly[2] && reset;
            if (lsb_req && !prev) begin
                if (exp_lsb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lsb_bit unexpected req pulse tx=%0b expected none", lsb_tx);
                end else begin
                    check("lsb_bit", lsb_tx, exp_lsb_q.pop_front());
                end
            end
            if (lsb_fin) lsb_fin_cnt++;
            if (lsb_err) lsb_err_cnt++;
            prev = lsb_req;
        end
    end

    task automatic push_seq(input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) exp_bit_q.push_back(seq[7-i]);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        data_in = d;
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        data_in = ~d;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic run_word(input logic [7:0] d, input logic [7:0] seq);
        int f0, e0, p0;
        f0 = fin_cnt;
        e0 = err_cnt;
        p0 = pulses;
        push_seq(seq, 8);
        exp_evt_q.push_back({4'd1, 4'd0});
        send(d);
        wait_idle("word_idle", 400);
        check("word_finish", fin_cnt - f0, 1);
        check("word_error", err_cnt - e0, 0);
        check("word_pulses", pulses - p0, 8);
        check("word_retry", retry_cnt, 0);
        check("word_bits_left", exp_bit_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] vec_d[4];
        logic [7:0] vec_s[4];
        int f0, e0, p0, n;
        vec_d = '{8'hA5, 8'h3C, 8'h80, 8'hFF};
        vec_s = '{8'hA5, 8'h3C, 8'h80, 8'hFF};

        reset = 1'b0;
        sent = 1'b0;
        data_in = '0;
        lsb_sent = 1'b0;
        lsb_data = '0;
        repeat (3) @(negedge clk);
        check("rst_req", sendToOther, 0);
        check("rst_tx", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        check("rst_error", error, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // MSB-first words, responsive remote.
        for (int i = 0; i < 4; i++) run_word(vec_d[i], vec_s[i]);

        // LSB-first: 8'h01 sends 1 then seven 0s; 8'h6C sends 0,0,1,1,0,1,1,0.
        for (int i = 0; i < 8; i++) exp_lsb_q.push_back(i == 0 ? 1'b1 : 1'b0);
        @(negedge clk);
        lsb_data = 8'h01;
        lsb_sent = 1'b1;
        @(negedge clk);
        lsb_sent = 1'b0;
        n = 0;
        while (lsb_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("lsb_idle", lsb_busy, 0);
        begin
            logic [7:0] s;
            s = 8'h36;
            for (int i = 0; i < 8; i++) exp_lsb_q.push_back(s[7-i]);
        end
        @(negedge clk);
        lsb_data = 8'h6C;
        lsb_sent = 1'b1;
        @(negedge clk);
        lsb_sent = 1'b0;
        n = 0;
        while (lsb_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("lsb_idle2", lsb_busy, 0);
        check("lsb_finish", lsb_fin_cnt, 2);
        check("lsb_error", lsb_err_cnt, 0);
        check("lsb_bits_left", exp_lsb_q.size(), 0);

        // Remote holding acknowledge high: transmitter parks in ARM.
        remote_hold = 1'b1;
        repeat (4) @(negedge clk);
        f0 = fin_cnt;
        p0 = pulses;
        push_seq(8'h3C, 8);
        exp_evt_q.push_back({4'd1, 4'd0});
        send(8'h3C);
        repeat (3) @(negedge clk);
        check("arm_req_low", sendToOther, 0);
        check("arm_state", state_dbg, 1);
        check("arm_busy", busy, 1);
        remote_hold = 1'b0;
        wait_idle("arm_idle", 400);
        check("arm_finish", fin_cnt - f0, 1);
        check("arm_pulses", pulses - p0, 8);
        check("arm_retry", retry_cnt, 0);

        // Silent remote: three attempts of the first bit, then one error pulse.
        remote_silent = 1'b1;
        f0 = fin_cnt;
        e0 = err_cnt;
        p0 = pulses;
        for (int i = 0; i < 3; i++) exp_bit_q.push_back(1'b1);
        exp_evt_q.push_back({4'd2, 4'd2});
        send(8'hC3);
        wait_idle("to_idle", 400);
        check("to_error", err_cnt - e0, 1);
        check("to_finish", fin_cnt - f0, 0);
        check("to_pulses", pulses - p0, 3);
        check("to_retry", retry_cnt, 2);
        remote_silent = 1'b0;
        repeat (3) @(negedge clk);

        // Remote misses bit 4 of the first attempt; whole original word re-sent.
        drop_idx = req_idx + 5;
        f0 = fin_cnt;
        e0 = err_cnt;
        p0 = pulses;
        push_seq(8'h96, 5);
        push_seq(8'h96, 8);
        exp_evt_q.push_back({4'd1, 4'd1});
        send(8'h96);
        wait_idle("rt_idle", 600);
        check("rt_finish", fin_cnt - f0, 1);
        check("rt_error", err_cnt - e0, 0);
        check("rt_pulses", pulses - p0, 13);
        check("rt_retry", retry_cnt, 1);
        check("rt_bits_left", exp_bit_q.size(), 0);

        // Reset mid-bit, then a clean word with an ignored strobe while busy.
        f0 = fin_cnt;
        e0 = err_cnt;
        push_seq(8'hD2, 8);
        send(8'hD2);
        n = 0;
        while (!sendToOther && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_req_seen", sendToOther, 1);
        reset = 1'b0;
        #1;
        exp_bit_q.delete();
        check("mid_rst_req", sendToOther, 0);
        check("mid_rst_tx", tx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_finish", finish, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        p0 = pulses;
        push_seq(8'h4B, 8);
        exp_evt_q.push_back({4'd1, 4'd0});
        send(8'h4B);
        repeat (4) @(negedge clk);
        data_in = 8'hFF;
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        wait_idle("post_idle", 400);
        repeat (5) @(negedge clk);
        check("post_no_restart", busy, 0);
        check("post_finish", fin_cnt - f0, 1);
        check("post_error", err_cnt - e0, 0);
        check("post_pulses", pulses - p0, 8);
        check("post_bits_left", exp_bit_q.size(), 0);
        check("evt_left", exp_evt_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
